// File: rtl/dadda_mul_pipe.sv
// Pipelined, parametrised Dadda-tree multiplier with per-operation signed/unsigned mode.
// Three register stages (operands -> reduced rows -> final sum) share one enable,
// so the output side sees a fixed latency and strict in-order results.
// Signed mode uses Baugh-Wooley partial products feeding the same reduction tree.
module dadda_mul_pipe #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int PW   = 2 * WIDTH;   // product width / number of bit-heap columns
   localparam int HMAX = WIDTH + 1;   // deepest any column can get, with headroom

   generate
      if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
         $error("dadda_mul_pipe: WIDTH must be 4, 8, 16 or 32");
      end
   endgenerate

   // Dadda reduction of the partial-product heap down to two rows.
   // Column heights depend only on WIDTH, so every loop and index here is
   // fixed at elaboration; only the bit values are data dependent.
   function automatic logic [2*PW-1:0] dadda_reduce(input logic [WIDTH*WIDTH-1:0] pp,
                                                    input logic corr);
      logic          col  [PW][HMAX];
      logic          ncol [PW][HMAX];
      int            h    [PW];
      int            nh   [PW];
      int            cin  [PW];
      int            maxh, d, dn, eff, k;
      logic [PW-1:0] row0, row1;
      for (int c = 0; c < PW; c++) begin
         h[c] = 0;
         for (int r = 0; r < HMAX; r++) col[c][r] = 1'b0;
      end
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            col[i+j][h[i+j]] = pp[i*WIDTH+j];
            h[i+j] = h[i+j] + 1;
         end
      end
      // Baugh-Wooley correction constants, present only in signed mode
      col[WIDTH][h[WIDTH]] = corr;
      h[WIDTH] = h[WIDTH] + 1;
      col[PW-1][h[PW-1]] = corr;
      h[PW-1] = h[PW-1] + 1;
      for (int s = 0; s < 10; s++) begin
         maxh = 0;
         for (int c = 0; c < PW; c++) if (h[c] > maxh) maxh = h[c];
         if (maxh > 2) begin
            // largest member of 2,3,4,6,9,13,19,28 strictly below the tallest column
            d  = 2;
            dn = 3;
            for (int q = 0; q < 10; q++) begin
               if (dn < maxh) begin
                  d  = dn;
                  dn = (dn * 3) / 2;
               end
            end
            for (int c = 0; c < PW; c++) begin
               nh[c]  = 0;
               cin[c] = 0;
               for (int r = 0; r < HMAX; r++) ncol[c][r] = 1'b0;
            end
            for (int c = 0; c < PW; c++) begin
               // carries arriving from the column below count towards this column's height
               eff = h[c] + cin[c];
               k   = 0;
               for (int r = 0; r < HMAX; r++) begin
                  if (eff > d && eff - d >= 2 && k + 2 < h[c]) begin
                     ncol[c][nh[c]] = col[c][k] ^ col[c][k+1] ^ col[c][k+2];
                     nh[c] = nh[c] + 1;
                     if (c + 1 < PW) begin
                        ncol[c+1][nh[c+1]] = (col[c][k] & col[c][k+1]) |
                                             (col[c][k] & col[c][k+2]) |
                                             (col[c][k+1] & col[c][k+2]);
                        nh[c+1]  = nh[c+1] + 1;
                        cin[c+1] = cin[c+1] + 1;
                     end
                     k   = k + 3;
                     eff = eff - 2;
                  end else if (eff > d && k + 1 < h[c]) begin
                     // half adder only when one bit over the target height
                     ncol[c][nh[c]] = col[c][k] ^ col[c][k+1];
                     nh[c] = nh[c] + 1;
                     if (c + 1 < PW) begin
                        ncol[c+1][nh[c+1]] = col[c][k] & col[c][k+1];
                        nh[c+1]  = nh[c+1] + 1;
                        cin[c+1] = cin[c+1] + 1;
                     end
                     k   = k + 2;
                     eff = eff - 1;
                  end
               end
               for (int r = 0; r < HMAX; r++) begin
                  if (r >= k && r < h[c]) begin
                     ncol[c][nh[c]] = col[c][r];
                     nh[c] = nh[c] + 1;
                  end
               end
            end
            for (int c = 0; c < PW; c++) begin
               h[c] = nh[c];
               for (int r = 0; r < HMAX; r++) col[c][r] = ncol[c][r];
            end
         end
      end
      for (int c = 0; c < PW; c++) begin
         row0[c] = col[c][0];
         row1[c] = col[c][1];
      end
      return {row1, row0};
   endfunction

   logic                   advance;
   logic                   v1_reg, v2_reg, v3_reg;
   logic [WIDTH-1:0]       a1_reg, b1_reg;
   logic                   sgn1_reg;
   logic [TAG_W-1:0]       tag1_reg, tag2_reg, tag3_reg;
   logic [PW-1:0]          row0_reg, row1_reg, prod_reg;
   logic [WIDTH*WIDTH-1:0] pp_flat;
   logic [2*PW-1:0]        rows_next;

   // global enable: every stage holds (bubbles included) while the output is blocked
   assign advance     = !v3_reg || out_ready;
   assign in_ready    = advance;
   assign out_valid   = v3_reg;
   assign out_product = prod_reg;
   assign out_tag     = tag3_reg;
   assign busy        = v1_reg | v2_reg | v3_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp_row
         for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pp_col
            if ((gi == WIDTH-1) != (gj == WIDTH-1)) begin : g_cross
               // sign row/column cross terms are complemented in signed mode
               assign pp_flat[gi*WIDTH+gj] = (b1_reg[gi] & a1_reg[gj]) ^ sgn1_reg;
            end else begin : g_plain
               assign pp_flat[gi*WIDTH+gj] = b1_reg[gi] & a1_reg[gj];
            end
         end
      end
   endgenerate

   // partial products of stage 1 reduced to two rows
   always_comb begin
      rows_next = dadda_reduce(pp_flat, sgn1_reg);
   end

   // stage 1: capture operands, mode and tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_reg   <= 1'b0;
         a1_reg   <= '0;
         b1_reg   <= '0;
         sgn1_reg <= 1'b0;
         tag1_reg <= '0;
      end else if (advance) begin
         v1_reg <= in_valid;
         if (in_valid) begin
            a1_reg   <= in_a;
            b1_reg   <= in_b;
            sgn1_reg <= in_signed;
            tag1_reg <= in_tag;
         end
      end
   end

   // stage 2: capture the two reduced rows
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_reg   <= 1'b0;
         row0_reg <= '0;
         row1_reg <= '0;
         tag2_reg <= '0;
      end else if (advance) begin
         v2_reg <= v1_reg;
         if (v1_reg) begin
            row0_reg <= rows_next[PW-1:0];
            row1_reg <= rows_next[2*PW-1:PW];
            tag2_reg <= tag1_reg;
         end
      end
   end

   // stage 3: final carry-propagate add; data only loads for real operations so
   // the product reads zero until the first result after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_reg   <= 1'b0;
         prod_reg <= '0;
         tag3_reg <= '0;
      end else if (advance) begin
         v3_reg <= v2_reg;
         if (v2_reg) begin
            prod_reg <= row0_reg + row1_reg;
            tag3_reg <= tag2_reg;
         end
      end
   end

endmodule

// File: tb/tb_dadda_mul_pipe.sv
// Directed bench for dadda_mul_pipe: WIDTH=8 main instance plus WIDTH=4/16/32 sweep instances.
module tb_dadda_mul_pipe;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // WIDTH=8 instance
   logic        in_valid, in_ready, in_signed, out_valid, out_ready, busy;
   logic [7:0]  in_a, in_b;
   logic [3:0]  in_tag, out_tag;
   logic [15:0] out_product;

   // sweep instances
   logic        w4_iv, w4_ir, w4_s, w4_ov, w4_busy;
   logic [3:0]  w4_a, w4_b, w4_tag, w4_otag;
   logic [7:0]  w4_p;
   logic        w16_iv, w16_ir, w16_s, w16_ov, w16_busy;
   logic [15:0] w16_a, w16_b;
   logic [3:0]  w16_tag, w16_otag;
   logic [31:0] w16_p;
   logic        w32_iv, w32_ir, w32_s, w32_ov, w32_busy;
   logic [31:0] w32_a, w32_b;
   logic [3:0]  w32_tag, w32_otag;
   logic [63:0] w32_p;
   logic        sweep_ready;

   dadda_mul_pipe #(.WIDTH(8), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
      .out_tag(out_tag), .busy(busy)
   );

   dadda_mul_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(w4_iv), .in_ready(w4_ir),
      .in_a(w4_a), .in_b(w4_b), .in_signed(w4_s), .in_tag(w4_tag),
      .out_valid(w4_ov), .out_ready(sweep_ready), .out_product(w4_p),
      .out_tag(w4_otag), .busy(w4_busy)
   );

   dadda_mul_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(w16_iv), .in_ready(w16_ir),
      .in_a(w16_a), .in_b(w16_b), .in_signed(w16_s), .in_tag(w16_tag),
      .out_valid(w16_ov), .out_ready(sweep_ready), .out_product(w16_p),
      .out_tag(w16_otag), .busy(w16_busy)
   );

   dadda_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(w32_iv), .in_ready(w32_ir),
      .in_a(w32_a), .in_b(w32_b), .in_signed(w32_s), .in_tag(w32_tag),
      .out_valid(w32_ov), .out_ready(sweep_ready), .out_product(w32_p),
      .out_tag(w32_otag), .busy(w32_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: sign-extend to 64 bits, multiply, keep 2*w bits
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic s);
      logic [63:0] a64, b64, m, p;
      m   = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
      a64 = {32'd0, a};
      b64 = {32'd0, b};
      if (s && a[w-1]) a64 = a64 | ~((64'd1 << w) - 64'd1);
      if (s && b[w-1]) b64 = b64 | ~((64'd1 << w) - 64'd1);
      p = a64 * b64;
      return p & m;
   endfunction

   function automatic logic [31:0] pick(input int w, input int k);
      logic [31:0] v;
      if (k == 0)      v = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      else if (k == 1) v = 32'd1 << (w - 1);
      else             v = 32'd1;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one op on the WIDTH=8 instance; pipeline assumed idle; lat counts the accept cycle as 1
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [3:0] tag, output logic [15:0] prod,
                          output logic [3:0] tag_o, output int lat);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_tag    = tag;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat   = -1;
      prod  = '0;
      tag_o = '0;
      for (int c = 1; c <= 10 && lat < 0; c++) begin
         if (out_valid) begin
            lat   = c;
            prod  = out_product;
            tag_o = out_tag;
         end else begin
            step();
         end
      end
      $display("op a=%h b=%h signed=%0d tag=%0d -> product=%h tag=%0d latency=%0d",
               a, b, s, tag, prod, tag_o, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready); end
      total++; if (out_product !== 16'h0000) begin bad++; $display("FAIL reset_product: got=%h exp=0000", out_product); end
      total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_tag: got=%h exp=0", out_tag); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_idle: got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
      $display("reset checked");
   endtask

   task automatic test_unsigned();
      logic [15:0] p;
      logic [3:0]  t;
      int          lat;
      run_op8(8'hFF, 8'hFF, 1'b0, 4'd3, p, t, lat);
      total++; if (p !== 16'hFE01) begin bad++; $display("FAIL u_ffxff_prod: got=%h exp=fe01", p); end
      total++; if (t !== 4'd3) begin bad++; $display("FAIL u_ffxff_tag: got=%0d exp=3", t); end
      total++; if (lat != 3) begin bad++; $display("FAIL u_ffxff_latency: got=%0d exp=3", lat); end
      run_op8(8'd0, 8'd200, 1'b0, 4'd5, p, t, lat);
      total++; if (p !== 16'h0000) begin bad++; $display("FAIL u_0x200_prod: got=%h exp=0000", p); end
      total++; if (t !== 4'd5) begin bad++; $display("FAIL u_0x200_tag: got=%0d exp=5", t); end
   endtask

   task automatic test_signed();
      logic [15:0] p;
      logic [3:0]  t;
      int          lat;
      run_op8(8'h80, 8'h80, 1'b1, 4'd1, p, t, lat);
      total++; if (p !== 16'h4000) begin bad++; $display("FAIL s_m128sq_prod: got=%h exp=4000", p); end
      run_op8(8'hFF, 8'h7F, 1'b1, 4'd2, p, t, lat);
      total++; if (p !== 16'hFF81) begin bad++; $display("FAIL s_m1x127_prod: got=%h exp=ff81", p); end
      total++; if (lat != 3) begin bad++; $display("FAIL s_m1x127_latency: got=%0d exp=3", lat); end
      run_op8(8'hFF, 8'h7F, 1'b0, 4'd4, p, t, lat);
      total++; if (p !== 16'h7E81) begin bad++; $display("FAIL u_255x127_prod: got=%h exp=7e81", p); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  av [16];
      logic [7:0]  bv [16];
      logic        sv [16];
      logic [15:0] ev [16];
      logic [63:0] tmp;
      for (int i = 0; i < 16; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
         sv[i] = 1'($urandom_range(0, 1));
         tmp   = ref_mul(8, {24'd0, av[i]}, {24'd0, bv[i]}, sv[i]);
         ev[i] = tmp[15:0];
      end
      out_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         if (c < 16) begin
            in_valid  = 1'b1;
            in_a      = av[c];
            in_b      = bv[c];
            in_signed = sv[c];
            in_tag    = 4'(c);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cycle %0d: got=%b exp=1", c, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (c >= 2) begin
            $display("b2b op %0d a=%h b=%h signed=%0d -> valid=%b product=%h tag=%0d (exp %h)",
                     c - 2, av[c-2], bv[c-2], sv[c-2], out_valid, out_product, out_tag, ev[c-2]);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid op %0d: got=%b exp=1", c - 2, out_valid); end
            total++; if (out_product !== ev[c-2]) begin bad++; $display("FAIL b2b_prod op %0d: got=%h exp=%h", c - 2, out_product, ev[c-2]); end
            total++; if (out_tag !== 4'(c - 2)) begin bad++; $display("FAIL b2b_tag op %0d: got=%0d exp=%0d", c - 2, out_tag, c - 2); end
         end
      end
      step();
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_drained: got valid=%b busy=%b exp 0 0", out_valid, busy); end
   endtask

   task automatic test_backpressure();
      logic [7:0]  av [4] = '{8'd12, 8'h80, 8'h10, 8'h05};
      logic [7:0]  bv [4] = '{8'd13, 8'h02, 8'h10, 8'hFB};
      logic        sv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] ev [4] = '{16'h009C, 16'hFF00, 16'h0100, 16'hFFE7};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         in_a      = av[i];
         in_b      = bv[i];
         in_signed = sv[i];
         in_tag    = 4'(8 + i);
         if (i < 3) step();
      end
      // op 3 is offered throughout the stall and must not be taken
      for (int c = 0; c < 5; c++) begin
         $display("stall cycle %0d: in_ready=%b valid=%b product=%h tag=%0d", c, in_ready, out_valid, out_product, out_tag);
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle %0d: got=%b exp=0", c, in_ready); end
         total++; if (out_valid !== 1'b1 || out_product !== ev[0] || out_tag !== 4'd8) begin
            bad++; $display("FAIL bp_hold cycle %0d: got valid=%b prod=%h tag=%0d exp 1 %h 8", c, out_valid, out_product, out_tag, ev[0]);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         $display("drain op %0d: valid=%b product=%h tag=%0d (exp %h)", k, out_valid, out_product, out_tag, ev[k]);
         total++; if (out_valid !== 1'b1 || out_product !== ev[k] || out_tag !== 4'(8 + k)) begin
            bad++; $display("FAIL bp_drain op %0d: got valid=%b prod=%h tag=%0d exp 1 %h %0d", k, out_valid, out_product, out_tag, ev[k], 8 + k);
         end
         step();
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] p;
      logic [3:0]  t;
      int          lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_signed = 1'b0;
      in_a = 8'd3;  in_b = 8'd3;  in_tag = 4'd1;
      step();
      in_a = 8'd4;  in_b = 8'd4;  in_tag = 4'd2;
      step();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async_clear: got valid=%b busy=%b exp 0 0", out_valid, busy); end
      total++; if (in_ready !== 1'b1 || out_product !== 16'h0000) begin bad++; $display("FAIL rmid_ready_prod: got ready=%b prod=%h exp 1 0000", in_ready, out_product); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         total++; if (out_valid !== 1'b0 || out_product !== 16'h0000) begin
            bad++; $display("FAIL rmid_no_stale cycle %0d: got valid=%b prod=%h exp 0 0000", c, out_valid, out_product);
         end
      end
      run_op8(8'd9, 8'd7, 1'b0, 4'd6, p, t, lat);
      total++; if (p !== 16'h003F || t !== 4'd6 || lat != 3) begin
         bad++; $display("FAIL rmid_new_op: got prod=%h tag=%0d lat=%0d exp 003f 6 3", p, t, lat);
      end
      step();
   endtask

   task automatic test_width_sweep();
      logic [31:0] va, vb;
      logic        s;
      logic [63:0] e4 [18];
      logic [63:0] e16 [18];
      logic [63:0] e32 [18];
      for (int c = 0; c < 20; c++) begin
         if (c < 18) begin
            s = (c >= 9);
            va = pick(4, c % 3);  vb = pick(4, (c / 3) % 3);
            w4_iv = 1'b1; w4_a = va[3:0]; w4_b = vb[3:0]; w4_s = s; w4_tag = 4'(c);
            e4[c] = ref_mul(4, va, vb, s);
            va = pick(16, c % 3); vb = pick(16, (c / 3) % 3);
            w16_iv = 1'b1; w16_a = va[15:0]; w16_b = vb[15:0]; w16_s = s; w16_tag = 4'(c);
            e16[c] = ref_mul(16, va, vb, s);
            va = pick(32, c % 3); vb = pick(32, (c / 3) % 3);
            w32_iv = 1'b1; w32_a = va; w32_b = vb; w32_s = s; w32_tag = 4'(c);
            e32[c] = ref_mul(32, va, vb, s);
         end else begin
            w4_iv = 1'b0; w16_iv = 1'b0; w32_iv = 1'b0;
         end
         step();
         if (c >= 2) begin
            $display("sweep op %0d: w4=%h w16=%h w32=%h", c - 2, w4_p, w16_p, w32_p);
            total++; if (w4_ov !== 1'b1 || {56'd0, w4_p} !== e4[c-2]) begin bad++; $display("FAIL sweep_w4 op %0d: got valid=%b prod=%h exp %h", c - 2, w4_ov, w4_p, e4[c-2]); end
            total++; if (w16_ov !== 1'b1 || {32'd0, w16_p} !== e16[c-2]) begin bad++; $display("FAIL sweep_w16 op %0d: got valid=%b prod=%h exp %h", c - 2, w16_ov, w16_p, e16[c-2]); end
            total++; if (w32_ov !== 1'b1 || w32_p !== e32[c-2]) begin bad++; $display("FAIL sweep_w32 op %0d: got valid=%b prod=%h exp %h", c - 2, w32_ov, w32_p, e32[c-2]); end
         end
      end
   endtask

   task automatic test_width4_exhaustive();
      logic [63:0] ev [512];
      logic [31:0] va, vb;
      int          errs;
      errs = 0;
      for (int c = 0; c < 514; c++) begin
         if (c < 512) begin
            va = 32'(c % 16);
            vb = 32'((c / 16) % 16);
            w4_iv = 1'b1; w4_a = va[3:0]; w4_b = vb[3:0]; w4_s = (c >= 256); w4_tag = 4'(c);
            ev[c] = ref_mul(4, va, vb, c >= 256);
         end else begin
            w4_iv = 1'b0;
         end
         step();
         if (c >= 2) begin
            total++; if (w4_ov !== 1'b1 || {56'd0, w4_p} !== ev[c-2]) begin
               bad++; errs++;
               $display("FAIL exh_w4 op %0d: got valid=%b prod=%h exp %h", c - 2, w4_ov, w4_p, ev[c-2]);
            end
         end
      end
      $display("width4 exhaustive: 512 ops compared, %0d differing", errs);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b0;
      sweep_ready = 1'b1;
      w4_iv = 1'b0;  w4_a = '0;  w4_b = '0;  w4_s = 1'b0;  w4_tag = '0;
      w16_iv = 1'b0; w16_a = '0; w16_b = '0; w16_s = 1'b0; w16_tag = '0;
      w32_iv = 1'b0; w32_a = '0; w32_b = '0; w32_s = 1'b0; w32_tag = '0;
      test_reset();
      test_unsigned();
      test_signed();
      step();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_width_sweep();
      test_width4_exhaustive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dadda_mul_pipe.md
Name: dadda_mul_pipe

Overview:
- Parametrised, pipelined Dadda-tree multiplier. Successor to the fixed 8x8 combinational unsigned Dadda multiplier.
- Adds configurable operand width, per-transaction signed/unsigned mode, a 3-register pipeline and valid/ready flow control with backpressure.
- Used as the multiply unit of the vector datapath; the upstream issue logic drives the input side and the writeback buffer drives the output side.

Parameters:
- WIDTH, 8, operand width in bits. Legal values: 4, 8, 16, 32. Any other value is a compile-time error.
- TAG_W, 4, width of the opaque tag that travels with each operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  block can accept an operation this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = both operands two's complement; 0 = both unsigned.
- in_tag  input  TAG_W  opaque ID, returned with the result.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_product  output  2*WIDTH  full-width product.
- out_tag  output  TAG_W  tag of the operation in out_product.
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Pipeline registers:
  - S1: operands, mode and tag; partial-product generation follows S1.
  - S2: Dadda reduction to two rows of 2*WIDTH bits, plus tag.
  - S3: final carry-propagate sum; drives the out_* ports.
  - Each stage has a valid bit v1, v2, v3. out_valid = v3.
- Reduction:
  - Dadda height sequence 2, 3, 4, 6, 9, 13, 19, 28 ...
  - Each stage reduces to the largest sequence value below the current column height.
  - Uses only half adders and 3:2 full adders. Half adders are used only where Dadda requires them.
- Signed mode uses Baugh-Wooley:
  - Invert the MSB-row/column partial products, except pp[W-1][W-1].
  - Add constant 1 at bit WIDTH and at bit 2*WIDTH-1.
  - Product is modulo 2^(2*WIDTH).
  - The unsigned path reuses the same tree with correction terms gated off by the stage-1 mode bit.
- Flow control:
  - advance = !v3 || out_ready.
  - in_ready = advance, combinational. No other combinational path from out_ready.
  - The pipeline uses global enable: when advance=0, every stage register holds, including bubbles. Bubbles do not collapse.
  - On advance=1: v1 <= in_valid; v2 <= v1; v3 <= v2, and data moves with the valid bits.
- Handshakes:
  - Accept occurs on a rising edge with in_valid && in_ready.
  - Output transfer occurs on a rising edge with out_valid && out_ready.
  - A simultaneous accept and output transfer in the same cycle is legal and sustains 1 op/cycle.
- Latency and ordering:
  - An operation accepted at edge t, with no stall, appears with out_valid=1 after edge t+2, i.e. in the third cycle counting the accept cycle.
  - Each stall cycle adds exactly one cycle.
  - Results return strictly in acceptance order. The tag is never altered.
- Output stability: while out_valid=1 && out_ready=0, out_product and out_tag hold stable.
- Upstream protocol: in_valid may drop without in_ready; no obligation is placed on upstream.
- Reset:
  - rst_n low clears v1, v2, v3, out_product, out_tag and busy to 0 immediately, independent of clk.
  - in_ready = 1 during and after reset.
  - Operations in flight at reset are discarded; none are emitted afterwards.
  - The first accept is legal on the first rising edge with rst_n high.
- No X: data registers of invalid stages may hold stale values, but out_product must be 0 whenever out_valid has never been set since reset.

Test Plan:
- WIDTH=8, unsigned: 255*255 tag 3 -> out_product=0xFE01, out_tag=3, out_valid exactly 3 cycles after accept. Then 0*200 -> 0x0000.
- WIDTH=8, signed:
  - -128*-128 -> 0x4000.
  - -1*127 (0xFF, 0x7F) -> 0xFF81.
  - Same operands 0xFF*0x7F unsigned -> 0x7E81.
- Back-to-back: out_ready=1, 16 consecutive random ops, mixed modes -> 16 results in 16 consecutive cycles, in order, matching the reference model; in_ready never drops.
- Backpressure: fill 3 ops, hold out_ready=0 for 5 cycles -> in_ready=0, out_product stable; release -> ops drain in order, with a new accept in the same cycle as the first drain.
- Reset mid-operation: 2 ops in flight, pulse rst_n low between edges -> out_valid=0, busy=0 at once; no stale result appears afterwards; a new op returns its correct product.
- Width sweep: WIDTH=4, 16, 32 with extremes (all-ones, MSB-only, 1) in both modes -> match the reference model. Exhaustive check for WIDTH=4.
